imem_arbiter: RTL and testbench

- Shares the single-port instruction/unified memory between two requesters: port 0 (core fetch/load/store) and port 1 (boot loader / debug).
- Sits between the multicycle core, the loader, and the memory macro. The macro has a combinational read, a synchronous write, and word addressing from addr[ADDR_W-1:2].
- Provides a boot phase in which only the loader may access memory while the core is stalled, followed by round-robin arbitration with a loader lock option.

---
 rtl/imem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the single-port instruction/unified memory: a loader-only
// boot phase, then round-robin between core (m0) and loader (m1) with a loader lock.
module imem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter bit BOOT_ON_RESET = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  input  logic              m1_lock,
  input  logic              boot_done,
  output logic              core_stall,
  output logic [CNT_W-1:0]  boot_wr_count,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = BOOT_ON_RESET ? ST_BOOT : ST_RUN;

  state_e             state_r;
  logic               rr_last_r;
  logic               lock_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               m0_rvalid_r;
  logic               m1_rvalid_r;
  logic               m0_err_r;
  logic               m1_err_r;
  logic [31:0]        m0_rdata_r;
  logic [31:0]        m1_rdata_r;

  logic               boot_s;
  logic               gnt0_s;
  logic               gnt1_s;
  logic               al0_s;
  logic               al1_s;
  logic               sel_we_s;
  logic               sel_al_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [31:0]        sel_wd_s;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

  assign boot_s = (state_r == ST_BOOT);
  assign al0_s  = is_aligned(m0_addr[1:0]);
  assign al1_s  = is_aligned(m1_addr[1:0]);

  // Grant decision; no grant at all while reset is held so memory cannot be written.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (boot_s) begin
      gnt1_s = m1_req;
    end else if (m0_req && m1_req) begin
      if (lock_r) begin
        gnt1_s = 1'b1;
      end else if (rr_last_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else begin
      gnt0_s = m0_req;
      gnt1_s = m1_req;
    end
  end

  // Winner mux onto the memory bus; idle bus is all zeros.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_al_s   = 1'b0;
    sel_addr_s = {ADDR_W{1'b0}};
    sel_wd_s   = 32'h0000_0000;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        sel_we_s   = m0_we;
        sel_al_s   = al0_s;
        sel_addr_s = m0_addr;
        sel_wd_s   = m0_wdata;
      end
      2'b10: begin
        sel_we_s   = m1_we;
        sel_al_s   = al1_s;
        sel_addr_s = m1_addr;
        sel_wd_s   = m1_wdata;
      end
      default: begin
        sel_we_s   = 1'b0;
        sel_al_s   = 1'b0;
        sel_addr_s = {ADDR_W{1'b0}};
        sel_wd_s   = 32'h0000_0000;
      end
    endcase
  end

  assign m0_gnt        = gnt0_s;
  assign m1_gnt        = gnt1_s;
  assign mem_a         = sel_addr_s;
  assign mem_wd        = sel_wd_s;
  assign mem_we        = sel_we_s & sel_al_s;
  assign core_stall    = boot_s;
  assign boot_wr_count = cnt_r;
  assign m0_rvalid     = m0_rvalid_r;
  assign m1_rvalid     = m1_rvalid_r;
  assign m0_err        = m0_err_r;
  assign m1_err        = m1_err_r;
  assign m0_rdata      = m0_rdata_r;
  assign m1_rdata      = m1_rdata_r;

  // Phase FSM, arbitration history and saturating boot write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RESET_STATE;
      rr_last_r <= 1'b1;
      lock_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_BOOT: if (boot_done) state_r <= ST_RUN;
                 else           state_r <= ST_BOOT;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= RESET_STATE;
      endcase
      if (gnt1_s) begin
        rr_last_r <= 1'b1;
      end else if (gnt0_s) begin
        rr_last_r <= 1'b0;
      end else begin
        rr_last_r <= rr_last_r;
      end
      lock_r <= gnt1_s & m1_lock;
      if (boot_s && gnt1_s && m1_we && al1_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Core response: one-cycle rvalid for reads, err for misaligned, rdata held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_r <= 1'b0;
      m0_err_r    <= 1'b0;
      m0_rdata_r  <= 32'h0000_0000;
    end else begin
      m0_rvalid_r <= gnt0_s & ~m0_we;
      m0_err_r    <= gnt0_s & ~al0_s;
      if (gnt0_s && !al0_s) begin
        m0_rdata_r <= 32'h0000_0000;
      end else if (gnt0_s && !m0_we) begin
        m0_rdata_r <= mem_rd;
      end else begin
        m0_rdata_r <= m0_rdata_r;
      end
    end
  end

  // Loader response, same behaviour as the core port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_rvalid_r <= 1'b0;
      m1_err_r    <= 1'b0;
      m1_rdata_r  <= 32'h0000_0000;
    end else begin
      m1_rvalid_r <= gnt1_s & ~m1_we;
      m1_err_r    <= gnt1_s & ~al1_s;
      if (gnt1_s && !al1_s) begin
        m1_rdata_r <= 32'h0000_0000;
      end else if (gnt1_s && !m1_we) begin
        m1_rdata_r <= mem_rd;
      end else begin
        m1_rdata_r <= m1_rdata_r;
      end
    end
  end

  imem_arbiter_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_gnt     (gnt0_s),
    .m1_gnt     (gnt1_s),
    .core_stall (boot_s),
    .mem_we     (mem_we)
  );

endmodule

// Structural invariants of the arbiter.
module imem_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic m0_gnt,
  input logic m1_gnt,
  input logic core_stall,
  input logic mem_we
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(m0_gnt && m1_gnt));
  a_boot_no_core: assert property (@(posedge clk) disable iff (!rst_n) !(core_stall && m0_gnt));
  a_we_needs_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(mem_we && !(m0_gnt || m1_gnt)));

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small behavioural memory macro.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock, boot_done;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        core_stall;
  logic [15:0] boot_wr_count;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [31:0] mem [0:15];

  int checks;
  int failures;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .m1_lock(m1_lock), .boot_done(boot_done), .core_stall(core_stall),
    .boot_wr_count(boot_wr_count), .mem_a(mem_a), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro: combinational read, synchronous write, word addressed.
  assign mem_rd = mem[mem_a[5:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[5:2]] <= mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; boot_done = 1'b0; m1_lock = 1'b0;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_core_stall", {31'h0, core_stall}, 32'h1);
    chk("rst_boot_cnt", {16'h0, boot_wr_count}, 32'h0);
    chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Boot: loader writes word 0 while the core waits for a read of 0x4.
    drive0(1'b1, 1'b0, 32'h4, 32'h0);
    drive1(1'b1, 1'b1, 32'h0, 32'h0000_0013);
    #1;
    chk("boot1_m0_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("boot1_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    chk("boot1_mem_we", {31'h0, mem_we}, 32'h1);
    chk("boot1_mem_wd", mem_wd, 32'h0000_0013);
    tick();
    chk("boot1_cnt", {16'h0, boot_wr_count}, 32'h1);
    chk("boot1_stall", {31'h0, core_stall}, 32'h1);

    // Second boot write with boot_done in the same cycle.
    drive1(1'b1, 1'b1, 32'h4, 32'h0010_0093);
    boot_done = 1'b1;
    #1;
    chk("boot2_m0_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("boot2_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    tick();
    boot_done = 1'b0;
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("boot2_cnt", {16'h0, boot_wr_count}, 32'h2);
    chk("run_stall", {31'h0, core_stall}, 32'h0);
    chk("run_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    tick();
    chk("lat_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("lat_m0_rdata", m0_rdata, 32'h0010_0093);
    chk("lat_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);

    // Loader solo read of word 0; core rdata must hold.
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    chk("solo_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    tick();
    chk("solo_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("solo_m1_rdata", m1_rdata, 32'h0000_0013);
    chk("hold_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("hold_m0_rdata", m0_rdata, 32'h0010_0093);

    // Round-robin: last winner was m1, so m0 wins first.
    drive0(1'b1, 1'b0, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    chk("rr1_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("rr1_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    tick();
    chk("rr1_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("rr1_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("rr1_m0_rdata", m0_rdata, 32'h0000_0013);
    chk("rr2_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    tick();
    chk("rr2_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("rr2_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("rr2_m1_rdata", m1_rdata, 32'h0010_0093);
    chk("rr3_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    tick();
    chk("rr3_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    m1_lock = 1'b1;
    #1;
    chk("rr4_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    tick();
    chk("rr4_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);

    // Lock held: m1 keeps winning despite round-robin favouring m0.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_m1_gnt", {31'h0, m1_gnt}, 32'h1);
      chk("lock_m0_gnt", {31'h0, m0_gnt}, 32'h0);
      tick();
    end
    m1_lock = 1'b0;
    #1;
    chk("unlock_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    tick();
    chk("unlock_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    tick();

    // Misaligned write must not touch word 1.
    drive0(1'b1, 1'b1, 32'h6, 32'hDEAD_BEEF);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mis_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("mis_mem_we", {31'h0, mem_we}, 32'h0);
    tick();
    chk("mis_m0_err", {31'h0, m0_err}, 32'h1);
    chk("mis_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("mis_m0_rdata", m0_rdata, 32'h0);
    drive0(1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    chk("after_mis_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("after_mis_rdata", m0_rdata, 32'h0010_0093);
    chk("after_mis_err", {31'h0, m0_err}, 32'h0);

    // Misaligned loader read; boot_done ignored in RUN.
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 32'h5, 32'h0);
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    chk("mis_m1_err", {31'h0, m1_err}, 32'h1);
    chk("mis_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("mis_m1_rdata", m1_rdata, 32'h0);
    chk("run_keeps_stall0", {31'h0, core_stall}, 32'h0);
    chk("run_cnt_hold", {16'h0, boot_wr_count}, 32'h2);

    // Async reset while a read response is pending.
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    chk("pre_rst_rvalid", {31'h0, m0_rvalid}, 32'h1);
    #2;
    rst_n = 1'b0;
    drive1(1'b1, 1'b1, 32'h8, 32'h1234_5678);
    #1;
    chk("arst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("arst_stall", {31'h0, core_stall}, 32'h1);
    chk("arst_cnt", {16'h0, boot_wr_count}, 32'h0);
    chk("arst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("arst_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
